// File: rtl/svga_pkg.sv
// Shared SVGA 800x600@72 Hz timing constants.
//   Totals: 1040 clocks per line, 666 lines per frame, one pixel per 50 MHz clock.
//   *_SYNC_START is the first sync clock/line; *_SYNC_END is one past the last.
package svga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 56;
    localparam int H_SYNC   = 120;
    localparam int H_BACK   = 64;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 600;
    localparam int V_FRONT  = 37;
    localparam int V_SYNC   = 6;
    localparam int V_BACK   = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int X_W = 11;
    localparam int Y_W = 10;

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis (horizontal or vertical): a wrapping position counter plus
// registered sync decode and the next-state active decode.
//   clock       : rising-edge clock
//   reset       : synchronous active-high; parks count on the last position
//   advance     : step the counter this clock
//   count       : current position, 0..TOTAL-1
//   wrap        : count is on the last position (next advance wraps to 0)
//   active_next : the position loaded at the next edge lies in the active region
//   sync        : registered sync, POL while inside the sync window
module sync_axis_counter #(
    parameter int ACTIVE = 800,
    parameter int FRONT  = 56,
    parameter int SYNC   = 120,
    parameter int BACK   = 64,
    parameter bit POL    = 1'b1,
    parameter int WIDTH  = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             active_next,
    output logic             sync
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH:0]   ACT_END    = (WIDTH+1)'(ACTIVE);
    localparam logic [WIDTH:0]   SYNC_START = (WIDTH+1)'(ACTIVE + FRONT);
    localparam logic [WIDTH:0]   SYNC_END   = (WIDTH+1)'(ACTIVE + FRONT + SYNC);

    logic [WIDTH:0]   count_inc;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH:0]   next_ext;

    assign wrap      = (count == LAST);
    assign count_inc = {1'b0, count} + 1'b1;

    always_comb begin
        count_next = count;
        if (advance)
            count_next = wrap ? '0 : count_inc[WIDTH-1:0];
    end

    // Decodes look at the value being loaded so they line up with count.
    assign next_ext    = {1'b0, count_next};
    assign active_next = (next_ext < ACT_END);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= LAST;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            sync  <= ((next_ext >= SYNC_START) && (next_ext < SYNC_END)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/svga_timing_gen.sv
// SVGA raster timing generator, one pixel per clock.
//   clock        : 50 MHz pixel clock
//   reset        : synchronous active-high; parks on the last blanking pixel
//   hsync/vsync  : registered syncs, HSYNC_POL/VSYNC_POL when asserted
//   video_enable : registered, high inside the visible area
//   pixel_x/y    : current column/line, straight from the counters
//   frame_start  : registered one-clock pulse at (0, 0)
module svga_timing_gen
    import svga_pkg::*;
#(
    parameter int H_ACTIVE  = svga_pkg::H_ACTIVE,
    parameter int H_FRONT   = svga_pkg::H_FRONT,
    parameter int H_SYNC    = svga_pkg::H_SYNC,
    parameter int H_BACK    = svga_pkg::H_BACK,
    parameter int V_ACTIVE  = svga_pkg::V_ACTIVE,
    parameter int V_FRONT   = svga_pkg::V_FRONT,
    parameter int V_SYNC    = svga_pkg::V_SYNC,
    parameter int V_BACK    = svga_pkg::V_BACK,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    output logic           hsync,
    output logic           vsync,
    output logic           video_enable,
    output logic [X_W-1:0] pixel_x,
    output logic [Y_W-1:0] pixel_y,
    output logic           frame_start
);

    logic h_wrap, v_wrap;
    logic h_act_next, v_act_next;

    sync_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(HSYNC_POL), .WIDTH(X_W)
    ) u_h (
        .clock(clock), .reset(reset), .advance(1'b1),
        .count(pixel_x), .wrap(h_wrap), .active_next(h_act_next), .sync(hsync)
    );

    sync_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(VSYNC_POL), .WIDTH(Y_W)
    ) u_v (
        .clock(clock), .reset(reset), .advance(h_wrap),
        .count(pixel_y), .wrap(v_wrap), .active_next(v_act_next), .sync(vsync)
    );

    // Next position is (0, 0) exactly when both axes sit on their last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            video_enable <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            video_enable <= h_act_next & v_act_next;
            frame_start  <= h_wrap & v_wrap;
        end
    end

endmodule

// File: tb/tb_svga_timing_gen.sv
module tb_svga_timing_gen;

    // Instance A: real SVGA timing. Instance B: shrunken raster, inverted syncs,
    // so whole frames fit in a short run.
    localparam int AHA = 800, AHF = 56, AHS = 120, AHB = 64;
    localparam int AVA = 600, AVF = 37, AVS = 6,   AVB = 23;
    localparam int BHA = 10,  BHF = 3,  BHS = 4,   BHB = 2;
    localparam int BVA = 6,   BVF = 2,  BVS = 2,   BVB = 1;
    localparam int AHT = AHA + AHF + AHS + AHB, AVT = AVA + AVF + AVS + AVB;
    localparam int BHT = BHA + BHF + BHS + BHB, BVT = BVA + BVF + BVS + BVB;

    logic clock = 1'b0;
    logic rst_a, rst_b;
    logic hs_a, vs_a, ve_a, fs_a, hs_b, vs_b, ve_b, fs_b;
    logic [10:0] px_a, px_b;
    logic [9:0]  py_a, py_b;

    int errors = 0;
    int checks = 0;
    int ax, ay, bx, by;

    always #10 clock = ~clock;

    svga_timing_gen u_a (
        .clock(clock), .reset(rst_a), .hsync(hs_a), .vsync(vs_a),
        .video_enable(ve_a), .pixel_x(px_a), .pixel_y(py_a), .frame_start(fs_a)
    );

    svga_timing_gen #(
        .H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_ACTIVE(BVA), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_b (
        .clock(clock), .reset(rst_b), .hsync(hs_b), .vsync(vs_b),
        .video_enable(ve_b), .pixel_x(px_b), .pixel_y(py_b), .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs from the raster rules for position (x, y).
    task automatic chk_inst(input string nm, input int x, input int y, input bit rst,
                            input int ha, input int hf, input int hsw,
                            input int va, input int vf, input int vsw, input bit pol,
                            input logic [10:0] px, input logic [9:0] py,
                            input logic hs, input logic vs, input logic ve, input logic fs);
        bit e_hs, e_vs, e_ve, e_fs;
        e_ve = !rst && x < ha && y < va;
        e_fs = !rst && x == 0 && y == 0;
        e_hs = (!rst && x >= ha + hf && x < ha + hf + hsw) ? pol : !pol;
        e_vs = (!rst && y >= va + vf && y < va + vf + vsw) ? pol : !pol;
        chk({nm, ".x"},  32'(px), 32'(x));
        chk({nm, ".y"},  32'(py), 32'(y));
        chk({nm, ".hs"}, 32'(hs), 32'(e_hs));
        chk({nm, ".vs"}, 32'(vs), 32'(e_vs));
        chk({nm, ".ve"}, 32'(ve), 32'(e_ve));
        chk({nm, ".fs"}, 32'(fs), 32'(e_fs));
    endtask

    // One clock: advance both reference positions, then compare everything.
    task automatic tick();
        @(posedge clock);
        #1;
        if (rst_a) begin ax = AHT - 1; ay = AVT - 1; end
        else if (ax == AHT - 1) begin ax = 0; ay = (ay == AVT - 1) ? 0 : ay + 1; end
        else ax++;
        if (rst_b) begin bx = BHT - 1; by = BVT - 1; end
        else if (bx == BHT - 1) begin bx = 0; by = (by == BVT - 1) ? 0 : by + 1; end
        else bx++;
        chk_inst("a", ax, ay, rst_a, AHA, AHF, AHS, AVA, AVF, AVS, 1'b1,
                 px_a, py_a, hs_a, vs_a, ve_a, fs_a);
        chk_inst("b", bx, by, rst_b, BHA, BHF, BHS, BVA, BVF, BVS, 1'b0,
                 px_b, py_b, hs_b, vs_b, ve_b, fs_b);
    endtask

    initial begin
        int ve_cnt, hs_cnt, bvs_cnt, bfs_cnt, hs_rise, hs_fall, guard;
        logic prev_hs;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ax = 0; ay = 0; bx = 0; by = 0;

        // Reset held 5 clocks.
        repeat (5) tick();
        chk("rst.px", 32'(px_a), 32'd1039);
        chk("rst.py", 32'(py_a), 32'd665);
        chk("rst.ve", 32'(ve_a), 32'd0);
        chk("rst.hs", 32'(hs_a), 32'd0);
        chk("rst.vs", 32'(vs_a), 32'd0);
        chk("rst.b_hs_idle_high", 32'(hs_b), 32'd1);
        chk("rst.b_vs_idle_high", 32'(vs_b), 32'd1);

        // One full line on A (and several frames on B) from the release edge.
        rst_a = 1'b0;
        rst_b = 1'b0;
        ve_cnt = 0; hs_cnt = 0; bvs_cnt = 0; bfs_cnt = 0;
        hs_rise = -1; hs_fall = -1; prev_hs = 1'b0;
        for (int i = 0; i < AHT; i++) begin
            tick();
            if (i == 0) begin
                chk("first.px", 32'(px_a), 32'd0);
                chk("first.py", 32'(py_a), 32'd0);
                chk("first.ve", 32'(ve_a), 32'd1);
                chk("first.fs", 32'(fs_a), 32'd1);
            end
            if (ve_a) ve_cnt++;
            if (hs_a) hs_cnt++;
            if (hs_a && !prev_hs) hs_rise = int'(px_a);
            if (!hs_a && prev_hs) hs_fall = int'(px_a);
            prev_hs = hs_a;
            if (i < BHT * BVT) begin
                if (!vs_b) bvs_cnt++;
                if (fs_b) bfs_cnt++;
            end
        end
        chk("line.ve_clocks", 32'(ve_cnt), 32'd800);
        chk("line.hs_clocks", 32'(hs_cnt), 32'd120);
        chk("line.hs_rise_x", 32'(hs_rise), 32'd856);
        chk("line.hs_fall_x", 32'(hs_fall), 32'd976);
        chk("b_frame.vs_clocks", 32'(bvs_cnt), 32'(BVS * BHT));
        chk("b_frame.fs_pulses", 32'(bfs_cnt), 32'd1);
        tick();
        chk("line.next_px", 32'(px_a), 32'd0);
        chk("line.next_py", 32'(py_a), 32'd1);

        // Last visible line wrap on B: next line is blank.
        guard = 0;
        while (!(bx == BHT - 1 && by == BVA - 1) && guard < 1000) begin tick(); guard++; end
        chk("b_wrap.reached", 32'(guard < 1000), 32'd1);
        tick();
        chk("b_wrap.py", 32'(py_b), 32'(BVA));
        chk("b_wrap.ve", 32'(ve_b), 32'd0);

        // Mid-frame reset on B for one clock.
        guard = 0;
        while (!(bx == 5 && by == 3) && guard < 1000) begin tick(); guard++; end
        chk("b_mid.reached", 32'(guard < 1000), 32'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_mid.px", 32'(px_b), 32'(BHT - 1));
        chk("b_mid.py", 32'(py_b), 32'(BVT - 1));
        tick();
        chk("b_mid.fs", 32'(fs_b), 32'd1);
        chk("b_mid.px0", 32'(px_b), 32'd0);

        // Randomized reset pulses against the reference model.
        for (int i = 0; i < 6000; i++) begin
            rst_a = ($urandom_range(0, 2999) == 0);
            rst_b = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
